// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the RV32I core. It holds the PC and issues
// word-aligned requests to instruction memory over a valid/ready handshake.
// In-order responses are buffered in a DEPTH-entry FIFO of {pc, instr} and
// handed to decode over a second valid/ready handshake. A redirect
// (branch/jump) flushes the FIFO in the same cycle. Responses to requests that
// are already in flight when the redirect happens are counted and discarded
// as they arrive.
//
// Parameters
//   RESET_PC        first PC fetched after reset (word aligned)
//   DEPTH           FIFO entries; also caps buffered + in-flight requests (2..8)
//
// Ports
//   clk             single clock, rising edge
//   rst_n           synchronous active-low reset
//   imem_req_valid  request address valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   word-aligned fetch address (the current PC)
//   imem_rsp_valid  response data valid (in order, no backpressure)
//   imem_rsp_data   instruction word returned by memory
//   redirect_valid  change fetch path this cycle (overrides everything except reset)
//   redirect_pc     new PC; bits [1:0] are forced to 0
//   if_valid        instruction available to decode
//   if_ready        decode consumes the instruction this cycle
//   if_instr        instruction word at the FIFO head
//   if_pc           PC of if_instr
//   if_opcode       if_instr[6:0], feeds the type decoder directly
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    // Fetch PC and instruction FIFO
    logic [31:0]   r_pc;
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Outstanding-request bookkeeping
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    // Tag queue: PC of every accepted request, popped by every response.
    // It always holds exactly r_inflight entries, so it is never flushed by a
    // redirect; stale responses pop their own tags as they are discarded.
    logic [31:0]   r_tag [DEPTH];
    logic [PW-1:0] r_tag_wr_ptr;
    logic [PW-1:0] r_tag_rd_ptr;

    logic [CW:0]   w_occupancy;
    logic          w_credit;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credit: never let buffered + outstanding exceed the FIFO size, so every
    // response that is kept is guaranteed a free slot.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit    = w_occupancy < {1'b0, DEPTH_C};

    // rst_n gates the request so memory never sees one while held in reset.
    assign imem_req_valid = rst_n && !redirect_valid && w_credit;
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign if_valid  = (r_count != '0) && !redirect_valid;
    assign if_instr  = r_fifo_instr[r_rd_ptr];
    assign if_pc     = r_fifo_pc[r_rd_ptr];
    assign if_opcode = r_fifo_instr[r_rd_ptr][6:0];

    assign w_pop  = if_valid && if_ready;
    assign w_push = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

    // Low PC bits of a redirect target are discarded by design.
    assign w_unused = ^redirect_pc[1:0];

    // PC, pointers and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            // A response landing in the redirect cycle is itself stale and
            // is discarded here; everything still outstanding must be dropped.
            r_inflight <= r_inflight - CW'(imem_rsp_valid);
            r_drop     <= r_inflight - CW'(imem_rsp_valid);
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            r_inflight <= r_inflight + CW'(w_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Tag queue pointers follow the memory handshake only; redirects do not
    // touch them (see the tag queue note above).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_wr_ptr <= '0;
            r_tag_rd_ptr <= '0;
        end else begin
            if (w_fire) begin
                r_tag_wr_ptr <= ptr_inc(r_tag_wr_ptr);
            end
            if (imem_rsp_valid) begin
                r_tag_rd_ptr <= ptr_inc(r_tag_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag[r_tag_wr_ptr] <= r_pc;
        end
    end

    // FIFO storage is cleared on reset so decode sees zeros on if_pc/if_instr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd_ptr];
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the memory side: a kept response must always find a
    // free slot, and memory must never answer a request that was not issued.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == DEPTH_C) && !w_pop));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (r_inflight == '0)));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage (RESET_PC = 0x100, DEPTH = 4). A memory
// model with configurable latency answers accepted requests in order. A queue
// based reference model (PC, FIFO contents, outstanding-request tags, drop
// count) predicts every DUT output each cycle. Directed phases pin key
// behaviours with literal values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [63:0] m_fifo [$];
    logic [31:0] m_tags [$];
    int          m_drop;
    bit          prev_rst = 1'b0;

    // Memory model
    typedef struct packed {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t mem_q [$];
    int   last_due = -1;
    int   lat_min  = 1;
    int   lat_max  = 1;

    // DUT values sampled at the falling edge of the last cycle
    logic        s_req_valid, s_fire, s_if_valid, s_pop;
    logic [31:0] s_addr, s_if_pc, s_if_instr;
    logic [6:0]  s_opcode;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: present response, sample and compare at negedge,
    // advance model and memory at posedge.
    task automatic tick();
        logic        e_req, e_ifv, fired, popped;
        logic [31:0] tag;
        rsp_t        r;
        int          due;
        e_req = 1'b0;
        e_ifv = 1'b0;
        tag   = '0;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end

        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_fire      = imem_req_valid && imem_req_ready;
        s_addr      = imem_req_addr;
        s_if_valid  = if_valid;
        s_pop       = if_valid && if_ready;
        s_if_pc     = if_pc;
        s_if_instr  = if_instr;
        s_opcode    = if_opcode;

        if (rst_n) begin
            e_req = !redirect_valid && ((m_fifo.size() + m_tags.size()) < DEPTH);
            e_ifv = (m_fifo.size() != 0) && !redirect_valid;
            chk("req_valid", s_req_valid, e_req);
            chk("req_addr", s_addr, m_pc);
            chk("if_valid", s_if_valid, e_ifv);
            if (m_fifo.size() != 0) begin
                chk("if_pc", s_if_pc, m_fifo[0][63:32]);
                chk("if_instr", s_if_instr, m_fifo[0][31:0]);
                chk("if_opcode", s_opcode, m_fifo[0][6:0]);
            end
        end else begin
            chk("rst_req_valid", s_req_valid, 0);
            if (prev_rst) begin
                chk("rst_if_valid", s_if_valid, 0);
                chk("rst_if_pc", s_if_pc, 0);
                chk("rst_if_instr", s_if_instr, 0);
                chk("rst_if_opcode", s_opcode, 0);
                chk("rst_req_addr", s_addr, RPC);
            end
        end
        fired  = e_req && imem_req_ready;
        popped = e_ifv && if_ready;

        @(posedge clk);
        if (!rst_n) begin
            m_pc = RPC;
            m_fifo.delete();
            m_tags.delete();
            m_drop = 0;
            mem_q.delete();
            last_due = -1;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (imem_rsp_valid) begin
                void'(mem_q.pop_front());
                chk("rsp_has_request", (m_tags.size() != 0), 1);
                if (m_tags.size() != 0) tag = m_tags.pop_front();
            end
            if (redirect_valid) begin
                m_drop = m_tags.size();
                m_fifo.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (popped) void'(m_fifo.pop_front());
                if (imem_rsp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else m_fifo.push_back({tag, mem_word(tag)});
                end
                if (fired) begin
                    m_tags.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (s_fire) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                r.due  = due;
                r.data = mem_word(s_addr);
                mem_q.push_back(r);
                last_due = due;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int          first_valid;
        int          pops;
        int          fires;
        int          k;
        bit          found;
        logic [31:0] first_pc, first_instr;
        logic [6:0]  first_op;
        logic [31:0] pcs [$];

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        first_pc       = '0;
        first_instr    = '0;
        first_op       = '0;
        repeat (3) tick();

        // Reset release and streaming with a 1-cycle memory
        rst_n       = 1'b1;
        first_valid = -1;
        pops        = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i == 0) begin
                chk("first_req_valid", s_req_valid, 1);
                chk("first_req_addr", s_addr, 32'h0000_0100);
            end
            if (i == 1) chk("second_req_addr", s_addr, 32'h0000_0104);
            if (s_if_valid && first_valid < 0) begin
                first_valid = i;
                first_pc    = s_if_pc;
                first_instr = s_if_instr;
                first_op    = s_opcode;
            end
            if (s_pop) pops++;
        end
        chk("first_valid_cycle", first_valid, 2);
        chk("first_if_pc", first_pc, 32'h0000_0100);
        chk("first_if_instr", first_instr, 32'hBFEF_0113);
        chk("first_if_opcode", first_op, 7'h13);
        chk("stream_count", pops, 20);

        // Backpressure: redirect to a fresh path, then hold decode off
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        if_ready       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        fires = 0;
        repeat (10) begin
            tick();
            if (s_fire) fires++;
        end
        chk("bp_fires", fires, DEPTH);
        chk("bp_req_valid_low", s_req_valid, 0);
        if_ready = 1'b1;
        pcs.delete();
        repeat (6) begin
            tick();
            if (s_pop) pcs.push_back(s_if_pc);
        end
        chk("bp_release_n", pcs.size(), 6);
        for (int i = 0; i < 4 && i < pcs.size(); i++)
            chk("bp_release_pc", pcs[i], 32'h0000_0400 + 32'(4 * i));

        // Memory stall: address must hold at the redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_addr", s_addr, 32'h0000_0800);
            chk("stall_fire", s_fire, 0);
        end
        repeat (4) tick();   // drain stale responses
        imem_req_ready = 1'b1;

        // Redirect with two requests in flight to a 3-cycle memory
        lat_min = 3;
        lat_max = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 30) begin
            tick();
            if (s_if_valid) begin
                found    = 1'b1;
                first_pc = s_if_pc;
            end
            k++;
        end
        chk("redir_found", found, 1);
        chk("redir_first_pc", first_pc, 32'h0000_0200);

        // Redirect coinciding with a response and a ready decode
        lat_min = 1;
        lat_max = 1;
        repeat (8) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        chk("redir_cycle_if_valid", s_if_valid, 0);
        redirect_valid = 1'b0;
        tick();
        chk("post_redir_if_valid", s_if_valid, 0);
        repeat (4) tick();

        // PC wrap (low target bits are ignored)
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        chk("wrap_fire", s_fire, 1);
        tick();
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        repeat (6) tick();
        chk("pre_rst_if_valid", s_if_valid, 1);

        // Mid-stream reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("mid_rst_if_valid", s_if_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("restart_addr", s_addr, 32'h0000_0100);
        chk("restart_req_valid", s_req_valid, 1);

        // Randomized traffic
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            if_ready       = ($urandom_range(2, 0) != 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
